accel_arbiter: RTL and testbench
================================

ACCEL_ARBITER -- requirements
Module: accel_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand and result width.
REQ-002 SHALL have parameter KERNEL_SIZE, default 3; lanes L = KERNEL_SIZE*KERNEL_SIZE.
REQ-003 SHALL have parameter NUM_REQ, default 2, requester count (2..4).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 64, WAIT watchdog limit.
REQ-005 SHALL provide ports:
  axi_clk  in  1  single clock, all logic on rising edge
  axi_reset_n  in  1  asynchronous active-low reset
  req_valid  in  NUM_REQ  per-requester job request
  req_ready  out  NUM_REQ  per-requester accept strobe
  req_multiplier  in  NUM_REQ*L*DATA_WIDTH  requester i data window at slice i
  req_multiplicand  in  NUM_REQ*L*DATA_WIDTH  requester i filter set at slice i
  rsp_valid  out  NUM_REQ  one-cycle result strobe to owner
  rsp_data  out  DATA_WIDTH  shared result bus
  rsp_error  out  1  result is a timeout, qualified by rsp_valid
  accel_multiplier  out  L*DATA_WIDTH  to matrix accelerator multiplier_input
  accel_multiplicand  out  L*DATA_WIDTH  to matrix accelerator multiplicand_input
  accel_mstart  out  L  per-lane multiply start
  accel_final_accumulate  in  DATA_WIDTH  accelerator sum
  accel_final_ready  in  1  accelerator sum valid (level)
  busy  out  1  job in flight
  grant_id  out  clog2(NUM_REQ)  current/last owner

Function
REQ-006 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESPOND -> IDLE.
REQ-007 IDLE: if any req_valid, SHALL assert req_ready for exactly one winner that cycle, latch its operands and index, go to ISSUE.
REQ-008 Winner SHALL be round-robin: search starts at (last grant + 1) mod NUM_REQ; after reset search starts at 0.
REQ-009 Requests not granted SHALL not be latched; a requester may drop req_valid before grant without effect.
REQ-010 ISSUE: accel_mstart SHALL be all ones for exactly one cycle; latched operands SHALL hold on accel_* buses from ISSUE through RESPOND.
REQ-011 WAIT: SHALL exit on a rising edge of accel_final_ready (registered previous value 0, current 1), capturing accel_final_accumulate.
REQ-012 accel_final_ready edges in IDLE or ISSUE SHALL be ignored.
REQ-013 RESPOND: rsp_valid[owner] SHALL be 1 for one cycle with rsp_data = captured sum; other rsp_valid bits 0; then IDLE.
REQ-014 Latency: accept at cycle T, mstart at T+1, rsp_valid one cycle after the cycle final_ready edge is sampled; next accept no earlier than RESPOND+1.
REQ-015 busy SHALL be 1 in ISSUE, WAIT, RESPOND; 0 in IDLE.
REQ-016 rsp_data SHALL hold its value until next RESPOND; accel_* buses SHALL hold last operands in IDLE.

Reset
REQ-017 axi_reset_n low SHALL asynchronously force IDLE, req_ready=0, rsp_valid=0, rsp_data=0, rsp_error=0, accel_mstart=0, accel operand buses=0, busy=0, grant_id=0, RR pointer so next search starts at 0.
REQ-018 Reset mid-job SHALL drop the job with no rsp_valid; a stale final_ready edge after reset SHALL be ignored (IDLE).

Configuration
REQ-019 With ACCEL_ARB_TIMEOUT_EN defined: counter clears on WAIT entry; reaching TIMEOUT_CYCLES without edge -> RESPOND with rsp_error=1, rsp_data=0.
REQ-020 Without ACCEL_ARB_TIMEOUT_EN: no counter, WAIT is unbounded, rsp_error tied 0.

Structure
REQ-021 Shared package SHALL hold the FSM state enumeration and default DATA_WIDTH/KERNEL_SIZE constants.
REQ-022 Round-robin selection SHALL be sub-module rr_select (request vector + pointer -> one-hot grant, index).

Verification
REQ-023 Single: req_valid[0]=1, operands 9x1 and 9x2, accelerator model returns 18 after 5 cycles -> req_ready[0] one cycle, mstart=9'h1FF one cycle, rsp_valid[0]=1 with rsp_data=18.
REQ-024 Contention: req_valid=2'b11 held 4 jobs from reset -> grants 0,1,0,1; each rsp routed only to owner.
REQ-025 Spurious: final_ready pulse while IDLE then req_valid[1] -> no rsp_valid until the post-ISSUE edge.
REQ-026 Timeout (macro on, TIMEOUT_CYCLES=64): final_ready held 0 -> rsp_valid[owner] 64 cycles after WAIT entry, rsp_error=1, rsp_data=0; macro off -> busy stays 1.
REQ-027 Reset mid-WAIT: axi_reset_n low 2 cycles -> all outputs reset values immediately, later final_ready edge produces no rsp_valid, next grant goes to requester 0.

Source files
------------

// File: rtl/accel_arbiter_pkg.sv
// Shared definitions for the accelerator arbiter: FSM state encoding and
// default datapath geometry.
package accel_arbiter_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 32;
  localparam int DEFAULT_KERNEL_SIZE = 3;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_RESPOND = 2'd3;

endpackage

// File: rtl/accel_arbiter_rr_select.sv
// Round-robin picker: scans the request vector starting at ptr (wrapping at
// NUM_REQ) and returns the first requester as one-hot grant plus index.
module rr_select #(
  parameter  int NUM_REQ = 2,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               any
);

  logic [IW:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // one spare bit so ptr+i can exceed NUM_REQ-1 before the wrap
      cand = {1'b0, ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      if (!any && req[cand[IW-1:0]]) begin
        any                  = 1'b1;
        idx                  = cand[IW-1:0];
        grant[cand[IW-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/accel_arbiter.sv
// Multi-requester front end for the matrix accelerator: one job at a time,
// round-robin arbitration. Optional WAIT watchdog: ACCEL_ARB_TIMEOUT_EN.
module accel_arbiter
  import accel_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int KERNEL_SIZE    = DEFAULT_KERNEL_SIZE,
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                              axi_clk,
  input  logic                                              axi_reset_n,
  input  logic [NUM_REQ-1:0]                                req_valid,
  output logic [NUM_REQ-1:0]                                req_ready,
  input  logic [NUM_REQ*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] req_multiplier,
  input  logic [NUM_REQ*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] req_multiplicand,
  output logic [NUM_REQ-1:0]                                rsp_valid,
  output logic [DATA_WIDTH-1:0]                             rsp_data,
  output logic                                              rsp_error,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]     accel_multiplier,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]     accel_multiplicand,
  output logic [KERNEL_SIZE*KERNEL_SIZE-1:0]                accel_mstart,
  input  logic [DATA_WIDTH-1:0]                             accel_final_accumulate,
  input  logic                                              accel_final_ready,
  output logic                                              busy,
  output logic [$clog2(NUM_REQ)-1:0]                        grant_id,
  output logic [1:0]                                        state_dbg
);

  localparam int LANES = KERNEL_SIZE * KERNEL_SIZE;
  localparam int LW    = LANES * DATA_WIDTH;
  localparam int IW    = $clog2(NUM_REQ);

  // Handshake: in IDLE the winner sees req_ready=1 for the cycle in which its
  // req_valid is sampled; the job is accepted at that clock edge. Any other
  // requester is simply not accepted and may change or drop req_valid freely.

  state_t              state;
  logic [IW-1:0]       rr_ptr;
  logic [IW-1:0]       win_idx;
  logic [NUM_REQ-1:0]  win_onehot;
  logic                any_req;
  logic                ready_q;
  logic                ready_rise;
  logic                timeout_hit;

  rr_select #(.NUM_REQ(NUM_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (win_onehot),
    .idx   (win_idx),
    .any   (any_req)
  );

  assign ready_rise   = accel_final_ready & ~ready_q;
  assign req_ready    = (axi_reset_n && state == ST_IDLE) ? win_onehot : '0;
  assign rsp_valid    = (state == ST_RESPOND) ? (NUM_REQ'(1) << grant_id) : '0;
  assign accel_mstart = (state == ST_ISSUE) ? '1 : '0;
  assign busy         = (state != ST_IDLE);
  assign state_dbg    = state;

`ifdef ACCEL_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
  logic          err_q;

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      wait_cnt <= '0;
    end else if (state == ST_ISSUE) begin
      wait_cnt <= '0;
    end else if (state == ST_WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state == ST_WAIT) && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign rsp_error   = err_q && (state == ST_RESPOND);
`else
  assign timeout_hit = 1'b0;
  assign rsp_error   = 1'b0;
`endif

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state              <= ST_IDLE;
      rr_ptr             <= '0;
      grant_id           <= '0;
      accel_multiplier   <= '0;
      accel_multiplicand <= '0;
      rsp_data           <= '0;
      ready_q            <= 1'b0;
`ifdef ACCEL_ARB_TIMEOUT_EN
      err_q              <= 1'b0;
`endif
    end else begin
      ready_q <= accel_final_ready;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            accel_multiplier   <= req_multiplier[win_idx*LW +: LW];
            accel_multiplicand <= req_multiplicand[win_idx*LW +: LW];
            grant_id           <= win_idx;
            rr_ptr             <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            state              <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          // a real result wins over a watchdog expiry in the same cycle
          if (ready_rise) begin
            rsp_data <= accel_final_accumulate;
`ifdef ACCEL_ARB_TIMEOUT_EN
            err_q    <= 1'b0;
`endif
            state    <= ST_RESPOND;
          end else if (timeout_hit) begin
            rsp_data <= '0;
`ifdef ACCEL_ARB_TIMEOUT_EN
            err_q    <= 1'b1;
`endif
            state    <= ST_RESPOND;
          end
        end
        ST_RESPOND: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_arbiter.sv
// Directed bench for accel_arbiter: table of jobs plus hand sequences for
// spurious ready edges, WAIT watchdog and reset in the middle of a job.
module tb_accel_arbiter;

  localparam int DW = 32;
  localparam int K  = 3;
  localparam int NR = 2;
  localparam int L  = K * K;
  localparam int LW = L * DW;
  localparam int TO = 64;

  logic              axi_clk = 1'b0;
  logic              axi_reset_n = 1'b1;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*LW-1:0]  req_multiplier;
  logic [NR*LW-1:0]  req_multiplicand;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              rsp_error;
  logic [LW-1:0]     accel_multiplier;
  logic [LW-1:0]     accel_multiplicand;
  logic [L-1:0]      accel_mstart;
  logic [DW-1:0]     accel_final_accumulate;
  logic              accel_final_ready;
  logic              busy;
  logic [0:0]        grant_id;
  logic [1:0]        state_dbg;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic saw;

  typedef struct {
    bit         do_rst;
    logic [1:0] rv;
    int         m0, c0, m1, c1;
    int         lat;
    int         gid;
    bit         glitch;
  } vec_t;

  vec_t vecs[9];

  accel_arbiter #(
    .DATA_WIDTH(DW), .KERNEL_SIZE(K), .NUM_REQ(NR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .axi_clk                (axi_clk),
    .axi_reset_n            (axi_reset_n),
    .req_valid              (req_valid),
    .req_ready              (req_ready),
    .req_multiplier         (req_multiplier),
    .req_multiplicand       (req_multiplicand),
    .rsp_valid              (rsp_valid),
    .rsp_data               (rsp_data),
    .rsp_error              (rsp_error),
    .accel_multiplier       (accel_multiplier),
    .accel_multiplicand     (accel_multiplicand),
    .accel_mstart           (accel_mstart),
    .accel_final_accumulate (accel_final_accumulate),
    .accel_final_ready      (accel_final_ready),
    .busy                   (busy),
    .grant_id               (grant_id),
    .state_dbg              (state_dbg)
  );

  // clock / reset
  always #5 axi_clk = ~axi_clk;

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic do_reset();
    axi_reset_n = 1'b0;
    tick();
    tick();
    axi_reset_n = 1'b1;
  endtask

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] fill(input int v);
    logic [LW-1:0] r;
    r = '0;
    for (int j = 0; j < L; j++) r[j*DW +: DW] = DW'(v);
    return r;
  endfunction

  // driver: one complete job from accept to the return to IDLE
  task automatic run_job(input vec_t v);
    logic [LW-1:0] em, ec;
    logic [DW-1:0] sum;
    logic [NR-1:0] oh;
    if (v.do_rst) do_reset();
    tick();
    em  = (v.gid == 0) ? fill(v.m0) : fill(v.m1);
    ec  = (v.gid == 0) ? fill(v.c0) : fill(v.c1);
    sum = (v.gid == 0) ? DW'(L * v.m0 * v.c0) : DW'(L * v.m1 * v.c1);
    oh  = NR'(1) << v.gid;
    req_multiplier   = {fill(v.m1), fill(v.m0)};
    req_multiplicand = {fill(v.c1), fill(v.c0)};
    req_valid        = v.rv;
    @(negedge axi_clk);
    chk("idle_busy", LW'(busy), LW'(0));
    chk("accept_ready", LW'(req_ready), LW'(oh));
    exp_q.push_back(sum);

    tick();  // ISSUE
    req_multiplier   = ~req_multiplier;
    req_multiplicand = ~req_multiplicand;
    if (v.glitch) begin
      accel_final_ready      = 1'b1;
      accel_final_accumulate = 32'hBAD0_BAD0;
    end
    @(negedge axi_clk);
    chk("issue_mstart", LW'(accel_mstart), LW'({L{1'b1}}));
    chk("issue_busy", LW'(busy), LW'(1));
    chk("issue_mult_bus", accel_multiplier, em);
    chk("issue_mcand_bus", accel_multiplicand, ec);
    chk("issue_grant_id", LW'(grant_id), LW'(v.gid));
    chk("issue_no_ready", LW'(req_ready), LW'(0));

    tick();  // first WAIT cycle
    accel_final_ready = 1'b0;
    @(negedge axi_clk);
    chk("wait_mstart_low", LW'(accel_mstart), LW'(0));
    chk("wait_no_rsp", LW'(rsp_valid), LW'(0));
    for (int i = 1; i < v.lat; i++) tick();

    tick();
    accel_final_ready      = 1'b1;
    accel_final_accumulate = sum;
    @(negedge axi_clk);
    chk("edge_cycle_no_rsp", LW'(rsp_valid), LW'(0));

    tick();  // RESPOND
    @(negedge axi_clk);
    chk("rsp_valid_owner", LW'(rsp_valid), LW'(oh));
    chk("rsp_data", LW'(rsp_data), LW'(exp_q.pop_front()));
    chk("rsp_error", LW'(rsp_error), LW'(0));
    chk("respond_no_ready", LW'(req_ready), LW'(0));
    chk("respond_ops_hold", accel_multiplier, em);

    tick();  // back to IDLE
    req_valid              = '0;
    accel_final_ready      = 1'b0;
    accel_final_accumulate = '0;
    @(negedge axi_clk);
    chk("after_rsp_valid", LW'(rsp_valid), LW'(0));
    chk("after_busy", LW'(busy), LW'(0));
    chk("rsp_data_hold", LW'(rsp_data), LW'(sum));
    chk("idle_ops_hold", accel_multiplicand, ec);
  endtask

  initial begin
    req_valid              = '0;
    req_multiplier         = '0;
    req_multiplicand       = '0;
    accel_final_ready      = 1'b0;
    accel_final_accumulate = '0;
    saw                    = 1'b0;

    //            rst  rv     m0     c0 m1 c1 lat gid glitch
    vecs[0] = '{1'b1, 2'b01, 1,     2, 0, 0, 5, 0, 1'b0};
    vecs[1] = '{1'b1, 2'b11, 3,     4, 5, 6, 2, 0, 1'b0};
    vecs[2] = '{1'b0, 2'b11, 7,     1, 2, 9, 3, 1, 1'b1};
    vecs[3] = '{1'b0, 2'b11, 10,   10, 11, 3, 1, 0, 1'b0};
    vecs[4] = '{1'b0, 2'b11, 4,     4, 8, 8, 4, 1, 1'b0};
    vecs[5] = '{1'b0, 2'b10, 1,     1, 6, 7, 2, 1, 1'b1};
    vecs[6] = '{1'b0, 2'b01, 65536, 5, 0, 0, 1, 0, 1'b0};
    vecs[7] = '{1'b0, 2'b10, 0,     0, 3, 3, 2, 1, 1'b0};
    vecs[8] = '{1'b0, 2'b11, 2,     5, 9, 9, 2, 0, 1'b0};

    #2;
    do_reset();
    @(negedge axi_clk);
    chk("rst_busy", LW'(busy), LW'(0));
    chk("rst_req_ready", LW'(req_ready), LW'(0));
    chk("rst_rsp_valid", LW'(rsp_valid), LW'(0));
    chk("rst_rsp_data", LW'(rsp_data), LW'(0));
    chk("rst_rsp_error", LW'(rsp_error), LW'(0));
    chk("rst_mstart", LW'(accel_mstart), LW'(0));
    chk("rst_mult_bus", accel_multiplier, LW'(0));
    chk("rst_mcand_bus", accel_multiplicand, LW'(0));
    chk("rst_grant_id", LW'(grant_id), LW'(0));

    for (int i = 0; i < 7; i++) run_job(vecs[i]);

    // ready edge while IDLE must not produce a response
    tick();
    accel_final_ready      = 1'b1;
    accel_final_accumulate = 32'h0000_DEAD;
    @(negedge axi_clk);
    chk("spur_idle_rsp", LW'(rsp_valid), LW'(0));
    chk("spur_idle_busy", LW'(busy), LW'(0));
    tick();
    accel_final_ready = 1'b0;
    @(negedge axi_clk);
    chk("spur_idle_rsp2", LW'(rsp_valid), LW'(0));
    run_job(vecs[7]);

    // job whose result never arrives
    tick();
    req_multiplier   = {fill(0), fill(2)};
    req_multiplicand = {fill(0), fill(3)};
    req_valid        = 2'b01;
    @(negedge axi_clk);
    chk("to_accept", LW'(req_ready), LW'(2'b01));
    tick();
    req_valid = '0;
    tick();  // first WAIT cycle
    saw = 1'b0;
`ifdef ACCEL_ARB_TIMEOUT_EN
    for (int i = 0; i < TO; i++) begin
      @(negedge axi_clk);
      if (rsp_valid != '0) saw = 1'b1;
      tick();
    end
    chk("to_early_rsp", LW'(saw), LW'(0));
    @(negedge axi_clk);
    chk("to_rsp_valid", LW'(rsp_valid), LW'(2'b01));
    chk("to_rsp_error", LW'(rsp_error), LW'(1));
    chk("to_rsp_data", LW'(rsp_data), LW'(0));
    tick();
    @(negedge axi_clk);
    chk("to_idle_busy", LW'(busy), LW'(0));
`else
    for (int i = 0; i < 70; i++) begin
      @(negedge axi_clk);
      if (rsp_valid != '0) saw = 1'b1;
      tick();
    end
    chk("no_to_rsp", LW'(saw), LW'(0));
    @(negedge axi_clk);
    chk("no_to_busy", LW'(busy), LW'(1));
`endif
    do_reset();

    // reset while waiting for the accelerator
    tick();
    req_multiplier   = {fill(1), fill(4)};
    req_multiplicand = {fill(1), fill(4)};
    req_valid        = 2'b01;
    @(negedge axi_clk);
    chk("mid_accept", LW'(req_ready), LW'(2'b01));
    tick();  // ISSUE
    tick();  // WAIT
    tick();  // WAIT
    axi_reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", LW'(busy), LW'(0));
    chk("mid_rst_ready", LW'(req_ready), LW'(0));
    chk("mid_rst_rsp", LW'(rsp_valid), LW'(0));
    chk("mid_rst_mstart", LW'(accel_mstart), LW'(0));
    chk("mid_rst_bus", accel_multiplier, LW'(0));
    chk("mid_rst_grant_id", LW'(grant_id), LW'(0));
    tick();
    tick();
    axi_reset_n = 1'b1;
    req_valid   = '0;
    tick();
    accel_final_ready      = 1'b1;
    accel_final_accumulate = 32'h0000_0055;
    @(negedge axi_clk);
    chk("stale_edge_rsp", LW'(rsp_valid), LW'(0));
    tick();
    @(negedge axi_clk);
    chk("stale_edge_rsp2", LW'(rsp_valid), LW'(0));
    chk("stale_edge_busy", LW'(busy), LW'(0));
    tick();
    accel_final_ready      = 1'b0;
    accel_final_accumulate = '0;
    run_job(vecs[8]);

    chk("scoreboard_empty", LW'(exp_q.size()), LW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
